// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with one-hot registered grants, a per-grant
// hold limit, and back-to-back handover when the current grant is released.
module rr_arb4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_c,
    input  logic       req_d,
    input  logic       done,
    output logic       ga,
    output logic       gb,
    output logic       gc,
    output logic       gd,
    output logic       grant_valid,
    output logic [3:0] hold_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] hold_q,  hold_d;
    logic       gv_q,    gv_d;

    logic [3:0] req_vec;
    logic       any_req;
    logic [1:0] sel_idx;
    logic       release_c;

    assign req_vec = {req_d, req_c, req_b, req_a};
    assign any_req = |req_vec;

    // Scan from farthest to nearest so the nearest requester after last wins;
    // last itself is checked at distance 4, giving it the lowest priority.
    always_comb begin
        sel_idx = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (req_vec[last_q + 2'(k)]) begin
                sel_idx = last_q + 2'(k);
            end
        end
    end

    // In GRANT, last_q always points at the requester currently holding the grant.
    assign release_c = done | ~req_vec[last_q] | (hold_q == HOLD_LIM);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_GRANT;
                    grant_d = 4'b0001 << sel_idx;
                    last_d  = sel_idx;
                    hold_d  = 4'd1;
                end
            end
            S_GRANT: begin
                if (!release_c) begin
                    hold_d = hold_q + 4'd1;
                end else if (any_req) begin
                    grant_d = 4'b0001 << sel_idx;
                    last_d  = sel_idx;
                    hold_d  = 4'd1;
                end else begin
                    state_d = S_IDLE;
                    grant_d = 4'b0000;
                    hold_d  = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
                hold_d  = 4'd0;
            end
        endcase
        gv_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 4'b0000;
            last_q  <= 2'd3;
            hold_q  <= 4'd0;
            gv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gv_q    <= gv_d;
        end
    end

    assign ga          = grant_q[0];
    assign gb          = grant_q[1];
    assign gc          = grant_q[2];
    assign gd          = grant_q[3];
    assign grant_valid = gv_q;
    assign hold_cnt    = hold_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios plus randomized traffic compared
// against a cycle-level arbitration model kept in plain integer arithmetic.
module tb_rr_arb4;

    localparam int HM = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0, req_c = 1'b0, req_d = 1'b0;
    logic       done = 1'b0;
    logic       ga, gb, gc, gd, grant_valid;
    logic [3:0] hold_cnt;
    logic [3:0] g;

    int n_chk  = 0;
    int n_pass = 0;

    assign g = {gd, gc, gb, ga};

    rr_arb4 #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .done(done),
        .ga(ga), .gb(gb), .gc(gc), .gd(gd),
        .grant_valid(grant_valid), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic [3:0] r, input logic d);
        @(negedge clk);
        {req_d, req_c, req_b, req_a} = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {req_d, req_c, req_b, req_a} = 4'b0000;
        done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (g !== 4'b0000) $display("FAIL reset_grants got=%b want=0000", g); else n_pass++;
        n_chk++; if (grant_valid !== 1'b0) $display("FAIL reset_gv got=%b want=0", grant_valid); else n_pass++;
        n_chk++; if (hold_cnt !== 4'd0) $display("FAIL reset_hold got=%0d want=0", hold_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 1'b0);
        n_chk++; if (g !== 4'b0000) $display("FAIL idle_no_req got=%b want=0000", g); else n_pass++;
    endtask

    task automatic test_single();
        step(4'b0100, 1'b0);
        n_chk++; if (g !== 4'b0100) $display("FAIL single_grant got=%b want=0100", g); else n_pass++;
        n_chk++; if (grant_valid !== 1'b1) $display("FAIL single_gv got=%b want=1", grant_valid); else n_pass++;
        n_chk++; if (hold_cnt !== 4'd1) $display("FAIL single_hold got=%0d want=1", hold_cnt); else n_pass++;
        step(4'b0000, 1'b0);
        n_chk++; if (g !== 4'b0000) $display("FAIL single_release got=%b want=0000", g); else n_pass++;
    endtask

    task automatic test_rotation();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic [3:0] want;
        do_reset();
        step(4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            want = 4'b0001 << exp_seq[i];
            if (i > 0) step(4'b1111, 1'b1);
            n_chk++; if (g !== want) $display("FAIL rot_grant[%0d] got=%b want=%b", i, g, want); else n_pass++;
            n_chk++; if (hold_cnt !== 4'd1) $display("FAIL rot_hold1[%0d] got=%0d want=1", i, hold_cnt); else n_pass++;
            step(4'b1111, 1'b0);
            n_chk++; if (g !== want) $display("FAIL rot_keep[%0d] got=%b want=%b", i, g, want); else n_pass++;
            n_chk++; if (hold_cnt !== 4'd2) $display("FAIL rot_hold2[%0d] got=%0d want=2", i, hold_cnt); else n_pass++;
        end
        step(4'b0000, 1'b0);
        n_chk++; if (g !== 4'b0000) $display("FAIL rot_idle got=%b want=0000", g); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= HM; i++) begin
            step(4'b0010, 1'b0);
            n_chk++; if (g !== 4'b0010) $display("FAIL to_grant[%0d] got=%b want=0010", i, g); else n_pass++;
            n_chk++; if (hold_cnt !== 4'(i)) $display("FAIL to_hold[%0d] got=%0d want=%0d", i, hold_cnt, i); else n_pass++;
        end
        step(4'b0010, 1'b0);
        n_chk++; if (g !== 4'b0010) $display("FAIL to_regrant got=%b want=0010", g); else n_pass++;
        n_chk++; if (hold_cnt !== 4'd1) $display("FAIL to_fresh_hold got=%0d want=1", hold_cnt); else n_pass++;
        step(4'b0000, 1'b0);
    endtask

    task automatic test_timeout_done();
        do_reset();
        step(4'b0001, 1'b0);
        for (int i = 2; i <= HM; i++) begin
            step(4'b1011, 1'b0);
            n_chk++; if (g !== 4'b0001) $display("FAIL tod_keep[%0d] got=%b want=0001", i, g); else n_pass++;
        end
        n_chk++; if (hold_cnt !== 4'(HM)) $display("FAIL tod_at_max got=%0d want=%0d", hold_cnt, HM); else n_pass++;
        step(4'b1011, 1'b1);
        n_chk++; if (g !== 4'b0010) $display("FAIL tod_next got=%b want=0010", g); else n_pass++;
        n_chk++; if (hold_cnt !== 4'd1) $display("FAIL tod_hold got=%0d want=1", hold_cnt); else n_pass++;
        step(4'b0000, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        step(4'b1000, 1'b0);
        n_chk++; if (g !== 4'b1000) $display("FAIL ar_pre got=%b want=1000", g); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (g !== 4'b0000) $display("FAIL ar_grants got=%b want=0000", g); else n_pass++;
        n_chk++; if (grant_valid !== 1'b0) $display("FAIL ar_gv got=%b want=0", grant_valid); else n_pass++;
        n_chk++; if (hold_cnt !== 4'd0) $display("FAIL ar_hold got=%0d want=0", hold_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 1'b0);
        n_chk++; if (g !== 4'b0000) $display("FAIL ar_no_early got=%b want=0000", g); else n_pass++;
        step(4'b0001, 1'b0);
        n_chk++; if (g !== 4'b0001) $display("FAIL ar_after got=%b want=0001", g); else n_pass++;
        n_chk++; if (hold_cnt !== 4'd1) $display("FAIL ar_after_hold got=%0d want=1", hold_cnt); else n_pass++;
        step(4'b0000, 1'b0);
    endtask

    task automatic test_drop_idle();
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        n_chk++; if (hold_cnt !== 4'd2) $display("FAIL drop_pre_hold got=%0d want=2", hold_cnt); else n_pass++;
        step(4'b0000, 1'b0);
        n_chk++; if (g !== 4'b0000) $display("FAIL drop_grants got=%b want=0000", g); else n_pass++;
        n_chk++; if (grant_valid !== 1'b0) $display("FAIL drop_gv got=%b want=0", grant_valid); else n_pass++;
        n_chk++; if (hold_cnt !== 4'd0) $display("FAIL drop_hold got=%0d want=0", hold_cnt); else n_pass++;
        step(4'b0000, 1'b1);
        n_chk++; if ({g, grant_valid, hold_cnt} !== 9'd0) $display("FAIL idle_done got=%b/%b/%0d want=0000/0/0", g, grant_valid, hold_cnt); else n_pass++;
    endtask

    task automatic test_random();
        int cur, last, hold, sel;
        logic [3:0] r, want;
        logic d, rel;
        do_reset();
        cur = -1; last = 3; hold = 0;
        for (int c = 0; c < 400; c++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            d = ($urandom_range(0, 4) == 0);
            step(r, d);
            sel = -1;
            for (int k = 4; k >= 1; k--) if (r[(last + k) % 4]) sel = (last + k) % 4;
            rel = (cur < 0) || d || !r[cur] || (hold == HM);
            if (!rel) hold = hold + 1;
            else if (sel >= 0) begin cur = sel; last = sel; hold = 1; end
            else begin cur = -1; hold = 0; end
            want = (cur < 0) ? 4'b0000 : (4'b0001 << cur);
            n_chk++; if (g !== want) $display("FAIL rnd_grant[%0d] got=%b want=%b", c, g, want); else n_pass++;
            n_chk++; if (grant_valid !== (cur >= 0)) $display("FAIL rnd_gv[%0d] got=%b want=%b", c, grant_valid, cur >= 0); else n_pass++;
            n_chk++; if (hold_cnt !== 4'(hold)) $display("FAIL rnd_hold[%0d] got=%0d want=%0d", c, hold_cnt, hold); else n_pass++;
            n_chk++; if ($countones(g) > 1) $display("FAIL rnd_onehot[%0d] got=%b want=onehot", c, g); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_timeout_done();
        test_async_reset();
        test_drop_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive cycles one grant SHALL be held (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_a, req_b, req_c, req_d  input  1 each  request lines from the four requesters.
REQ-005 done  input  1  single-cycle pulse from the currently granted requester, releasing its grant.
REQ-006 ga, gb, gc, gd  output  1 each  registered grant lines; these feed the downstream 4-to-2 encoder inputs a, b, c, d directly.
REQ-007 grant_valid  output  1  registered; high whenever any of ga..gd is high.
REQ-008 hold_cnt  output  4  registered count of cycles the current grant has been held, for debug.

Function
REQ-009 ga..gd SHALL be one-hot or all-zero in every cycle; two grants high at once is illegal. The downstream encoder depends on this.
REQ-010 The block SHALL implement two states:
  - IDLE: no grant.
  - GRANT: exactly one grant high.
REQ-011 The block SHALL keep a 2-bit pointer last, holding the index of the most recent grant (a=0, b=1, c=2, d=3).
REQ-012 Selection SHALL search last+1, last+2, last+3, last (mod 4) and choose the first requester whose request is high.
REQ-013 IDLE with any req high SHALL cause the following on the next edge:
  - enter GRANT;
  - assert the selected grant;
  - set last to the selected index;
  - set hold_cnt to 1.
  This gives one-cycle request-to-grant latency.
REQ-014 IDLE with no req high SHALL remain in IDLE with all grants 0.
REQ-015 In GRANT, a release condition SHALL occur when any of the following holds:
  - done is high;
  - the granted requester's req is low;
  - hold_cnt equals HOLD_MAX.
REQ-016 In GRANT without a release condition, the grant SHALL persist and hold_cnt SHALL increment by 1.
REQ-017 On release with any req high, the next edge SHALL switch directly to the newly selected grant per REQ-012 (back-to-back, no idle cycle) and set hold_cnt to 1.
REQ-018 On release, the just-released requester SHALL be re-granted only when no other req is high; it then gets a fresh hold_cnt of 1.
REQ-019 On release with no req high, the next edge SHALL enter IDLE, clear all grants and clear hold_cnt to 0.
REQ-020 done SHALL be ignored in IDLE.
REQ-021 done coinciding with the timeout or with the req drop SHALL be treated as a single release; no grant SHALL be skipped.
REQ-022 Request changes of non-granted requesters during GRANT SHALL NOT affect the current grant.
REQ-023 hold_cnt SHALL never exceed HOLD_MAX and SHALL never wrap.
REQ-024 grant_valid SHALL equal (ga|gb|gc|gd) in every cycle.

Reset
REQ-025 rst_n low SHALL, immediately and independently of clk, force the following:
  - state IDLE;
  - ga..gd = 0;
  - grant_valid = 0;
  - hold_cnt = 0;
  - last = 3, so the first search starts at a.
REQ-026 Reset asserted mid-grant SHALL drop the grant within the same cycle, without waiting for a clock edge.
REQ-027 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge at which a req is sampled high.

Verification
REQ-028 Reset, then req_c=1 only -> gc=1, grant_valid=1 and hold_cnt=1 one edge later; ga=gb=gd=0.
REQ-029 All four req held high, done pulsed every 2nd cycle -> grant order a,b,c,d,a; each switch back-to-back; never two grants high.
REQ-030 req_b alone held high with HOLD_MAX=8, no done -> gb high exactly 8 cycles, hold_cnt 1..8, then re-granted to b with hold_cnt=1.
REQ-031 ga held, req_d and req_b high, timeout and done in the same cycle -> next grant is gb, hold_cnt=1.
REQ-032 gd granted, rst_n pulled low between edges -> gd=0, grant_valid=0 and hold_cnt=0 immediately; after release, req_a=1 yields ga one edge later.
REQ-033 Granted requester drops req with no others pending -> IDLE next edge, all grants 0, hold_cnt=0; done pulsed in IDLE -> no change.
